// File: rtl/ball_engine.sv
// ball_engine: ball position/velocity engine for the paddle game.
//
// Moves a square ball once per frame tick, bounces it off the top and bottom
// walls, returns it from either paddle with a speed-up, and reports a miss
// with a one-cycle score pulse. A serve/countdown sequencer holds the ball
// at the centre until a serve request and a fixed number of frame ticks.
//
// Ports:
//   clck        system clock
//   reset       asynchronous, active-high reset
//   vgax, vgay  current VGA pixel being drawn
//   update      one-cycle frame tick; all motion happens on update cycles
//   serve       one-cycle serve request (acted on only when idle)
//   paddle_l_y  left paddle top row
//   paddle_r_y  right paddle top row
//   pixel       registered: ball covers (vgax, vgay)
//   ball_x/y    ball top-left corner
//   score_l     one-cycle pulse: left player scored (ball exited right)
//   score_r     one-cycle pulse: right player scored (ball exited left)
//   playing     high while the ball is in play
module ball_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 10,
  parameter int VEL_W        = 4,
  parameter int INIT_SPEED   = 2,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X_L   = 16,
  parameter int PADDLE_X_R   = 616,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clck,
  input  logic       reset,
  input  logic [9:0] vgax,
  input  logic [8:0] vgay,
  input  logic       update,
  input  logic       serve,
  input  logic [8:0] paddle_l_y,
  input  logic [8:0] paddle_r_y,
  output logic       pixel,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       score_l,
  output logic       score_r,
  output logic       playing
);

  localparam int CW   = 12;
  localparam int CntW = $clog2(SERVE_FRAMES + 1);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StServeWait = 2'd1;
  localparam logic [1:0] StPlay      = 2'd2;
  localparam logic [1:0] StScored    = 2'd3;

  localparam logic [9:0] XCentre    = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [8:0] YCentre    = 9'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [9:0] XLeftStop  = 10'(PADDLE_X_L + PADDLE_W);
  localparam logic [9:0] XRightStop = 10'(PADDLE_X_R - BALL_SIZE);
  localparam logic [10:0] BallSpan  = 11'(BALL_SIZE - 1);

  localparam logic signed [CW-1:0] XMax      = CW'(SCREEN_W - BALL_SIZE);
  localparam logic signed [CW-1:0] YMax      = CW'(SCREEN_H - BALL_SIZE);
  localparam logic signed [CW-1:0] Ball      = CW'(BALL_SIZE);
  localparam logic signed [CW-1:0] PadH      = CW'(PADDLE_H);
  localparam logic signed [CW-1:0] LeftFace  = CW'(PADDLE_X_L + PADDLE_W);
  localparam logic signed [CW-1:0] RightFace = CW'(PADDLE_X_R);

  localparam logic [VEL_W-1:0] VMax     = {1'b0, {(VEL_W - 1){1'b1}}};
  localparam logic [VEL_W-1:0] VOne     = VEL_W'(1);
  localparam logic [VEL_W-1:0] VInit    = VEL_W'(INIT_SPEED);
  localparam logic [VEL_W-1:0] VInitNeg = VEL_W'(-INIT_SPEED);

  localparam logic [CntW-1:0] CntLoad = CntW'(SERVE_FRAMES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  // Velocities are stored as two's complement bit patterns.
  logic [VEL_W-1:0] xv_q, xv_d;
  logic [VEL_W-1:0] yv_q, yv_d;
  // Direction of the next serve: xv sign follows the last scorer, yv sign
  // alternates from point to point.
  logic             serve_xneg_q, serve_xneg_d;
  logic             serve_yneg_q, serve_yneg_d;
  logic             pixel_q, pixel_d;
  logic             score_l_q, score_l_d;
  logic             score_r_q, score_r_d;

  logic signed [CW-1:0] x_s, nx, ny, y_cl, pl_s, pr_s;
  logic                 y_bounce, ovl_l, ovl_r, hit_l, hit_r, xv_neg, xv_pos;
  logic [VEL_W-1:0]     xv_mag, xv_fast;
  logic [10:0]          x_hi;
  logic [9:0]           y_hi;

  // Candidate motion for this frame, plus wall and paddle decisions.
  always_comb begin
    x_s  = $signed({2'b00, x_q});
    nx   = x_s + $signed({{(CW - VEL_W){xv_q[VEL_W-1]}}, xv_q});
    ny   = $signed({3'b000, y_q}) + $signed({{(CW - VEL_W){yv_q[VEL_W-1]}}, yv_q});

    y_bounce = 1'b0;
    y_cl     = ny;
    if (ny[CW-1]) begin
      y_bounce = 1'b1;
      y_cl     = '0;
    end else if (ny > YMax) begin
      y_bounce = 1'b1;
      y_cl     = YMax;
    end

    // Paddle overlap is judged against the wall-clamped new row.
    pl_s  = $signed({3'b000, paddle_l_y});
    pr_s  = $signed({3'b000, paddle_r_y});
    ovl_l = (y_cl + Ball > pl_s) && (y_cl < pl_s + PadH);
    ovl_r = (y_cl + Ball > pr_s) && (y_cl < pr_s + PadH);

    xv_neg  = xv_q[VEL_W-1];
    xv_pos  = !xv_neg && (xv_q != '0);
    xv_mag  = xv_neg ? (~xv_q + VOne) : xv_q;
    xv_fast = (xv_mag >= VMax) ? VMax : (xv_mag + VOne);

    // A hit needs the ball to cross the paddle face during this frame.
    hit_l = xv_neg && (x_s >= LeftFace) && (nx < LeftFace) && ovl_l;
    hit_r = xv_pos && (x_s + Ball <= RightFace) && (nx + Ball > RightFace) && ovl_r;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    xv_d         = xv_q;
    yv_d         = yv_q;
    serve_xneg_d = serve_xneg_q;
    serve_yneg_d = serve_yneg_q;
    score_l_d    = 1'b0;
    score_r_d    = 1'b0;

    x_hi    = {1'b0, x_q} + BallSpan;
    y_hi    = {1'b0, y_q} + BallSpan[9:0];
    pixel_d = (vgax >= x_q) && ({1'b0, vgax} <= x_hi) &&
              (vgay >= y_q) && ({1'b0, vgay} <= y_hi);

    case (state_q)
      StIdle: begin
        if (serve) begin
          state_d = StServeWait;
          cnt_d   = CntLoad;
        end
      end
      StServeWait: begin
        if (update) begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) state_d = StPlay;
        end
      end
      StPlay: begin
        if (update) begin
          y_d = y_cl[8:0];
          if (y_bounce) yv_d = ~yv_q + VOne;
          if (hit_l) begin
            x_d  = XLeftStop;
            xv_d = xv_fast;
          end else if (hit_r) begin
            x_d  = XRightStop;
            xv_d = ~xv_fast + VOne;
          end else if (nx[CW-1]) begin
            // Exit left: x holds its pre-update value.
            score_r_d    = 1'b1;
            serve_xneg_d = 1'b1;
            state_d      = StScored;
          end else if (nx > XMax) begin
            score_l_d    = 1'b1;
            serve_xneg_d = 1'b0;
            state_d      = StScored;
          end else begin
            x_d = nx[9:0];
          end
        end
      end
      StScored: begin
        if (update) begin
          state_d      = StIdle;
          x_d          = XCentre;
          y_d          = YCentre;
          xv_d         = serve_xneg_q ? VInitNeg : VInit;
          yv_d         = serve_yneg_q ? VInit : VInitNeg;
          serve_yneg_d = !serve_yneg_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      x_q          <= XCentre;
      y_q          <= YCentre;
      xv_q         <= VInit;
      yv_q         <= VInit;
      serve_xneg_q <= 1'b0;
      serve_yneg_q <= 1'b0;
      pixel_q      <= 1'b0;
      score_l_q    <= 1'b0;
      score_r_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xv_q         <= xv_d;
      yv_q         <= yv_d;
      serve_xneg_q <= serve_xneg_d;
      serve_yneg_q <= serve_yneg_d;
      pixel_q      <= pixel_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
    end
  end

  assign pixel   = pixel_q;
  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign playing = (state_q == StPlay);

endmodule
